sobel_frame_ctrl: RTL and testbench
===================================

# sobel_frame_ctrl

Frame-level sequencer for the Sobel edge-detection core. On a `go` pulse it streams a full IMG_W×IMG_H greyscale frame from a synchronous-read pixel RAM into the core in raster order, and drives the core's `Start` and `Threshold`. It captures every valid result (edge bit plus gradient) into a result RAM, counts edge pixels, and reports completion. It sits between the frame buffers and the Sobel core, replacing the hand-sequenced stimulus used in bench bring-up.

## Interface
Parameters
- IMG_W, 256: frame width in pixels.
- IMG_H, 256: frame height in pixels.
- ADDR_W, 16: pixel/result address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H.
- DRAIN_MAX, 1024: maximum DRAIN cycles before timeout.

Ports (one clock; reset is synchronous and active-low)
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  synchronous active-low reset.
- go  in  1  start request, sampled only in IDLE.
- abort  in  1  synchronous abort, honoured in every state.
- threshold_in  in  8  edge threshold for the next frame.
- busy  out  1  high in FEED and DRAIN.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  sticky error flag; cleared by the next accepted `go`.
- edge_count  out  ADDR_W+1  number of results with edge=1 in the current/last frame.
- rd_en  out  1  pixel RAM read enable.
- rd_addr  out  ADDR_W  pixel RAM address.
- rd_data  in  8  pixel RAM data, valid one cycle after rd_en.
- core_start  out  1  to core `Start`.
- core_datain  out  8  to core `DataIn`.
- core_threshold  out  8  to core `Threshold`, stable for the whole frame.
- core_ready  in  1  core `isReady`.
- core_finish  in  1  core `Finish`.
- core_dop  in  1  core edge bit (`Dop`).
- core_gradient  in  8  core `Gradient`.
- wr_en  out  1  result RAM write enable.
- wr_addr  out  ADDR_W  result index.
- wr_edge  out  1  stored edge bit.
- wr_grad  out  8  stored gradient.

## Operation
- N = IMG_W·IMG_H. States are IDLE, FEED, DRAIN, DONE. All outputs are registered except `core_datain`, which is a direct pass-through of `rd_data`.
- **IDLE**
  - If `go` is 1: latch `threshold_in` into `core_threshold`, clear `rd_addr`, the result counter `out_cnt`, `edge_count` and `timeout`, then go to FEED.
  - `go` is ignored in every other state.
- **FEED**
  - `rd_en` = 1 and `rd_addr` increments by 1 each cycle, from 0 to N−1.
  - `core_start` rises the cycle after the first `rd_en`. The core therefore sees pixel k on its k-th start-high cycle.
  - After issuing the read of address N−1, go to DRAIN. `rd_en` drops and `rd_addr` holds N−1.
- **DRAIN**
  - `core_start` stays 1 and `rd_en` stays 0. A drain cycle counter runs.
  - Go to DONE when `out_cnt` = N, or `core_finish` rises (0→1).
  - Go to DONE with `timeout` = 1 when the drain counter reaches DRAIN_MAX.
- **DONE**
  - `core_start` = 0 and `done` = 1 for exactly one cycle, then go to IDLE.
- **Capture, in FEED and DRAIN**
  - Each cycle with `core_ready` = 1 and `core_finish` = 0 and `out_cnt` < N: on the next edge set `wr_en` = 1, `wr_addr` = `out_cnt`, `wr_edge` = `core_dop`, `wr_grad` = `core_gradient`; increment `out_cnt`; add `core_dop` to `edge_count`.
  - Results beyond N are dropped (no write, counters frozen).
- **Abort**
  - `abort` = 1 in any state: next state is IDLE.
  - `rd_en`, `core_start`, `wr_en` and `busy` drop next cycle; no `done` pulse.
  - `edge_count` holds its partial value.
  - `abort` and `go` in the same IDLE cycle: abort wins and the frame does not start.
- **Counter widths**
  - `out_cnt` and `edge_count` are ADDR_W+1 bits, so the value N is representable.
  - `rd_addr` never wraps.
- **Reset**, also mid-frame: state = IDLE and every output = 0, including `core_threshold`, `edge_count` and `timeout`.

## Timing
- `go` sampled at edge 0: `busy` = 1, `rd_en` = 1 and `rd_addr` = 0 during cycle 1; `core_start` = 1 from cycle 2.
- `rd_addr` = k during cycle k+1. The last read is in cycle N; DRAIN starts at cycle N+1.
- Write latency: a result is accepted at edge t and `wr_en` is high during cycle t+1.
- `done` is high in the cycle after the DRAIN exit condition. `busy` is 0 in that same cycle.
- Minimum gap between frames: `go` is accepted again in the cycle after `done`.
- `core_threshold` changes only at an accepted `go`.

## Test plan
- **Reset:** hold RSTn = 0 for 3 cycles with `go` = 1 → all outputs 0, state IDLE, no `rd_en`.
- **Nominal frame:** IMG_W = IMG_H = 4, threshold_in = 10, core model returns ready from cycle 5 with dop = addr[0] → `rd_addr` 0..15 on cycles 1..16; 16 writes with `wr_addr` 0..15; `edge_count` = 8; single `done` pulse; `timeout` = 0.
- **Early finish:** core raises `core_finish` after 10 results in DRAIN → exactly 10 writes, `done` pulse next cycle, no writes after finish.
- **Timeout:** core never asserts `core_ready`, DRAIN_MAX = 8 → `done` 8 cycles into DRAIN, `timeout` = 1, `edge_count` = 0; the next `go` clears `timeout`.
- **Abort:** `abort` at FEED cycle 5 → `rd_en` and `core_start` 0 next cycle, IDLE, no `done`; `go` + `abort` in the same IDLE cycle → stays IDLE.
- **Back-to-back:** `go` held high through DONE with threshold_in changed → second frame starts the cycle after `done`, with `core_threshold` updated only at that start.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: streams one pixel frame into the Sobel core,
// captures its results into a result RAM and counts edge pixels.
module sobel_frame_ctrl #(
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int ADDR_W    = 16,
  parameter int DRAIN_MAX = 1024
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              go,
  input  logic              abort,
  input  logic [7:0]        threshold_in,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W:0]   edge_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              core_start,
  output logic [7:0]        core_datain,
  output logic [7:0]        core_threshold,
  input  logic              core_ready,
  input  logic              core_finish,
  input  logic              core_dop,
  input  logic [7:0]        core_gradient,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_edge,
  output logic [7:0]        wr_grad
);
  localparam int N  = IMG_W * IMG_H;
  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [ADDR_W:0]   N_C  = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [DW-1:0]     DLIM = DW'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_FEED, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              to_q, to_d;
  logic [ADDR_W:0]   edge_q, edge_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              start_q, start_d;
  logic [7:0]        thr_q, thr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_edge_q, wr_edge_d;
  logic [7:0]        wr_grad_q, wr_grad_d;
  logic [DW-1:0]     drn_q, drn_d;
  logic              fin_q;
  logic              cap;
  logic              fin_rise;

  // Next-state, capture path and registered outputs.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    to_d      = to_q;
    edge_d    = edge_q;
    cnt_d     = cnt_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    start_d   = start_q;
    thr_d     = thr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_edge_d = wr_edge_q;
    wr_grad_d = wr_grad_q;
    drn_d     = drn_q;
    fin_rise  = core_finish & ~fin_q;
    cap       = !abort && core_ready && !core_finish
                && (cnt_q < N_C)
                && (state_q == S_FEED || state_q == S_DRAIN);

    if (cap) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_q[ADDR_W-1:0];
      wr_edge_d = core_dop;
      wr_grad_d = core_gradient;
      cnt_d     = cnt_q + (ADDR_W+1)'(1);
      edge_d    = edge_q + {{ADDR_W{1'b0}}, core_dop};
    end

    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      start_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          busy_d  = 1'b0;
          start_d = 1'b0;
          if (go) begin
            state_d   = S_FEED;
            thr_d     = threshold_in;
            rd_addr_d = '0;
            cnt_d     = '0;
            edge_d    = '0;
            to_d      = 1'b0;
            busy_d    = 1'b1;
            rd_en_d   = 1'b1;
          end
        end
        S_FEED: begin
          busy_d  = 1'b1;
          start_d = 1'b1;
          if (rd_addr_q == LAST) begin
            state_d = S_DRAIN;
            drn_d   = '0;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          busy_d  = 1'b1;
          start_d = 1'b1;
          drn_d   = drn_q + DW'(1);
          if (cnt_q == N_C || fin_rise) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            start_d = 1'b0;
          end else if (drn_q == DLIM) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            start_d = 1'b0;
            to_d    = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          start_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      edge_q    <= '0;
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      start_q   <= 1'b0;
      thr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_edge_q <= 1'b0;
      wr_grad_q <= '0;
      drn_q     <= '0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      to_q      <= to_d;
      edge_q    <= edge_d;
      cnt_q     <= cnt_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      start_q   <= start_d;
      thr_q     <= thr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_edge_q <= wr_edge_d;
      wr_grad_q <= wr_grad_d;
      drn_q     <= drn_d;
      fin_q     <= core_finish;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = to_q;
  assign edge_count     = edge_q;
  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign core_start     = start_q;
  assign core_datain    = rd_data;
  assign core_threshold = thr_q;
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_edge        = wr_edge_q;
  assign wr_grad        = wr_grad_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: directed frames with random core traffic,
// checked cycle by cycle against a frame-timeline model.
module tb_sobel_frame_ctrl;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int DM = 8;
  localparam int N  = W * H;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    threshold_in = '0;
  logic          busy, done, timeout;
  logic [AW:0]   edge_count;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = '0;
  logic          core_start;
  logic [7:0]    core_datain, core_threshold;
  logic          core_ready = 1'b0;
  logic          core_finish = 1'b0;
  logic          core_dop = 1'b0;
  logic [7:0]    core_gradient = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_edge;
  logic [7:0]    wr_grad;

  int errors = 0;
  int checks = 0;
  logic [7:0] pix [N];

  sobel_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DRAIN_MAX(DM)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .go(go), .abort(abort),
    .threshold_in(threshold_in), .busy(busy), .done(done),
    .timeout(timeout), .edge_count(edge_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .core_start(core_start), .core_datain(core_datain),
    .core_threshold(core_threshold), .core_ready(core_ready),
    .core_finish(core_finish), .core_dop(core_dop),
    .core_gradient(core_gradient), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_edge(wr_edge), .wr_grad(wr_grad)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read pixel RAM.
  always @(posedge CLK) if (rd_en) rd_data <= pix[rd_addr];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame: rfrom/pct shape core_ready, fin_after raises Finish
  // in DRAIN after that many results, par makes dop = result[0],
  // abort_at aborts in that cycle, keep_go holds go through the frame.
  task automatic run_frame(input logic [7:0] thr, input int rfrom,
                           input int pct, input int fin_after,
                           input bit par, input int abort_at,
                           input bit keep_go, input logic [7:0] nthr);
    int c, e, acc, edg;
    bit exp_wr, exp_to, fin_prev, fin, rdy, aborted, is_end;
    logic [AW-1:0] ew_addr;
    logic ew_edge, dp;
    logic [7:0] ew_grad, gr;
    for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
    go = 1'b1;
    threshold_in = thr;
    tick;
    if (!keep_go) go = 1'b0;
    acc = 0; edg = 0; e = 0; exp_wr = 0; exp_to = 0;
    fin_prev = 0; aborted = 0;
    ew_addr = '0; ew_edge = 0; ew_grad = '0;
    for (c = 1; c <= N + DM + 2; c++) begin
      is_end = (e != 0 && c == e);
      chk("busy", busy, !is_end);
      chk("done", done, is_end);
      chk("rd_en", rd_en, c <= N);
      chk("rd_addr", rd_addr, (c <= N) ? c - 1 : N - 1);
      chk("core_start", core_start, c >= 2 && !is_end);
      chk("core_thr", core_threshold, thr);
      chk("wr_en", wr_en, exp_wr);
      if (exp_wr) begin
        chk("wr_addr", wr_addr, ew_addr);
        chk("wr_edge", wr_edge, ew_edge);
        chk("wr_grad", wr_grad, ew_grad);
      end
      if (c >= 2 && c <= N + 1) chk("datain", core_datain, pix[c-2]);
      chk("timeout", timeout, is_end ? exp_to : 1'b0);
      if (is_end) begin
        chk("edge_count", edge_count, edg);
        break;
      end
      if (keep_go && c == 3) threshold_in = nthr;
      if (c == abort_at) begin
        abort = 1'b1;
        core_ready = 1'b1;
        core_dop = 1'b1;
        aborted = 1;
        break;
      end
      fin = (fin_after >= 0) && (c > N) && (acc >= fin_after);
      rdy = (c >= rfrom) && ($urandom_range(99) < pct);
      dp = par ? acc[0] : 1'($urandom);
      gr = 8'($urandom);
      core_ready = rdy;
      core_finish = fin;
      core_dop = dp;
      core_gradient = gr;
      if (c > N) begin
        if (acc == N || (fin && !fin_prev)) e = c + 1;
        else if (c - N == DM) begin
          e = c + 1;
          exp_to = 1;
        end
      end
      exp_wr = rdy && !fin && acc < N;
      if (exp_wr) begin
        ew_addr = AW'(acc);
        ew_edge = dp;
        ew_grad = gr;
        acc++;
        edg += int'(dp);
      end
      fin_prev = fin;
      tick;
    end
    if (aborted) begin
      tick;
      abort = 1'b0;
      core_ready = 1'b0;
      core_dop = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_rd_en", rd_en, 0);
      chk("abort_start", core_start, 0);
      chk("abort_wr_en", wr_en, 0);
      chk("abort_done", done, 0);
      chk("abort_edges", edge_count, edg);
      for (int k = 0; k < 4; k++) begin
        tick;
        chk("abort_idle_done", done, 0);
        chk("abort_idle_busy", busy, 0);
      end
    end else begin
      core_ready = 1'b0;
      core_finish = 1'b0;
      tick;
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_wr_en", wr_en, 0);
      chk("post_timeout", timeout, exp_to);
      chk("post_thr", core_threshold, thr);
    end
  endtask

  initial begin
    logic [7:0] t;
    // Reset held with go asserted.
    RSTn = 1'b0;
    go = 1'b1;
    threshold_in = 8'hA5;
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_edges", edge_count, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_start", core_start, 0);
    chk("rst_thr", core_threshold, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_edge", wr_edge, 0);
    chk("rst_wr_grad", wr_grad, 0);
    go = 1'b0;
    RSTn = 1'b1;
    tick;
    chk("idle_busy", busy, 0);

    // Nominal frame: ready from cycle 5, dop alternates, 8 edges.
    run_frame(8'd10, 5, 100, -1, 1, 0, 0, 8'd0);
    chk("nominal_edges", edge_count, 8);

    // Random core traffic.
    run_frame(8'($urandom), 2, 80, -1, 0, 0, 0, 8'd0);
    run_frame(8'($urandom), 1, 60, -1, 0, 0, 0, 8'd0);

    // Early finish after 10 results.
    run_frame(8'd33, 12, 100, 10, 0, 0, 0, 8'd0);
    chk("finish_wr_addr", wr_addr, 9);

    // Core never ready: drain timeout.
    run_frame(8'd77, 1, 0, -1, 0, 0, 0, 8'd0);
    chk("to_sticky", timeout, 1);
    chk("to_edges", edge_count, 0);

    // Next go clears timeout.
    run_frame(8'($urandom), 2, 90, -1, 0, 0, 0, 8'd0);

    // Abort in FEED cycle 5.
    run_frame(8'd44, 2, 100, -1, 0, 5, 0, 8'd0);

    // go and abort together in IDLE.
    go = 1'b1;
    abort = 1'b1;
    threshold_in = 8'hEE;
    tick;
    go = 1'b0;
    abort = 1'b0;
    chk("ga_busy", busy, 0);
    chk("ga_rd_en", rd_en, 0);
    chk("ga_thr", core_threshold, 8'd44);
    tick;
    chk("ga_busy2", busy, 0);

    // Back-to-back frames with go held through DONE.
    t = 8'($urandom);
    run_frame(8'h20, 2, 90, -1, 0, 0, 1, t);
    run_frame(t, 2, 90, -1, 0, 0, 0, 8'd0);

    // Reset in the middle of a frame.
    go = 1'b1;
    threshold_in = 8'h66;
    tick;
    go = 1'b0;
    core_ready = 1'b1;
    core_dop = 1'b1;
    repeat (3) tick;
    RSTn = 1'b0;
    tick;
    core_ready = 1'b0;
    core_dop = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_rd_en", rd_en, 0);
    chk("mrst_rd_addr", rd_addr, 0);
    chk("mrst_start", core_start, 0);
    chk("mrst_thr", core_threshold, 0);
    chk("mrst_edges", edge_count, 0);
    chk("mrst_wr_en", wr_en, 0);
    chk("mrst_timeout", timeout, 0);
    RSTn = 1'b1;
    tick;
    chk("mrst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
